warp_arbiter: RTL

- Arbitrates the shared decoder/ALU/PC execute datapath between NUM_WARPS warps (register-file/LSU/fetcher sets) inside a multi-warp compute core.
- Each warp raises a request when it holds a fetched instruction ready for decode.
- The arbiter grants exactly one warp at a time, per instruction, in round-robin order.
- It drives warp_select, which steers the shared datapath muxes and register-file enables.
- It inserts a one-cycle turnaround bubble when ownership changes between different warps.

---
 rtl/gpu_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 30 +++
 rtl/warp_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gpu_arb_pkg.sv
// Shared types and helpers for the warp datapath arbiter.
package gpu_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWNED,
    ARB_SWITCH
  } arb_state_t;

  // Supports up to 8 warps; OR-ing the indices of set bits yields the index of a one-hot input.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[3'(i)]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or above rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_WARPS = 2,
  parameter int unsigned WARP_BITS = 1
) (
  input  logic [NUM_WARPS-1:0] req,
  input  logic [WARP_BITS-1:0] rr_ptr,
  output logic                 found,
  output logic [WARP_BITS-1:0] winner
);

  always_comb begin
    int unsigned k;
    logic [WARP_BITS-1:0] idx;
    found  = 1'b0;
    winner = rr_ptr;
    k      = 0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      k = 32'(rr_ptr) + i;
      if (k >= NUM_WARPS) k = k - NUM_WARPS;
      idx = WARP_BITS'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/warp_arbiter.sv
// Round-robin owner of the shared decode/ALU/PC datapath with a one-cycle bubble on owner change.
// Define WARP_ARB_TIMEOUT_EN to build the hold watchdog; `release` is reserved, so that port is rel.
module warp_arbiter #(
  parameter int unsigned NUM_WARPS = 2,
  parameter int unsigned WARP_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int unsigned MAX_HOLD  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WARPS-1:0] req,
  input  logic [NUM_WARPS-1:0] rel,
  output logic [NUM_WARPS-1:0] grant,
  output logic                 grant_valid,
  output logic [WARP_BITS-1:0] warp_select,
  output logic                 timeout_err
);
  import gpu_arb_pkg::*;

  arb_state_t           state_q, state_d;
  logic [NUM_WARPS-1:0] grant_q, grant_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [WARP_BITS-1:0] sel_q, sel_d;
  logic [WARP_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [WARP_BITS-1:0] pend_q, pend_d;
  logic [WARP_BITS-1:0] owner, pick_ptr, pick_winner;
  logic                 pick_found, grant_start, timeout_hit, end_of_grant;

  function automatic logic [WARP_BITS-1:0] next_idx(input logic [WARP_BITS-1:0] i);
    return (32'(i) == NUM_WARPS - 1) ? '0 : i + 1'b1;
  endfunction

  assign owner    = WARP_BITS'(onehot_to_idx(8'(grant_q)));
  // Scanning from owner+1 leaves the owner last, so it wins only as the sole requester.
  assign pick_ptr = (state_q == ARB_OWNED) ? next_idx(owner) : rr_ptr_q;

  rr_pick #(
    .NUM_WARPS(NUM_WARPS),
    .WARP_BITS(WARP_BITS)
  ) u_pick (
    .req   (req),
    .rr_ptr(pick_ptr),
    .found (pick_found),
    .winner(pick_winner)
  );

`ifdef WARP_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_BITS = $clog2(MAX_HOLD + 1);
  logic [HOLD_BITS-1:0] hold_q, hold_d;
  logic                 timeout_err_q, timeout_err_d;

  // Fires on the last allowed OWNED cycle so the grant is visible exactly MAX_HOLD cycles.
  assign timeout_hit   = (state_q == ARB_OWNED) && (hold_q == HOLD_BITS'(MAX_HOLD - 1));
  assign timeout_err_d = timeout_err_q | timeout_hit;
  assign timeout_err   = timeout_err_q;

  always_comb begin
    hold_d = hold_q;
    if (grant_start)               hold_d = '0;
    else if (state_q == ARB_OWNED) hold_d = hold_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign end_of_grant = !req[owner] || rel[owner] || timeout_hit;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    pend_d      = pend_q;
    grant_start = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d     = NUM_WARPS'(1) << pick_winner;
          sel_d       = pick_winner;
          state_d     = ARB_OWNED;
          grant_start = 1'b1;
        end
      end
      ARB_OWNED: begin
        if (end_of_grant) begin
          rr_ptr_d = next_idx(owner);
          if (!pick_found) begin
            grant_d = '0;
            state_d = ARB_IDLE;
          end else if (pick_winner == owner) begin
            grant_start = 1'b1;
          end else begin
            grant_d = '0;
            pend_d  = pick_winner;
            state_d = ARB_SWITCH;
          end
        end
      end
      ARB_SWITCH: begin
        if (req[pend_q]) begin
          grant_d     = NUM_WARPS'(1) << pend_q;
          sel_d       = pend_q;
          state_d     = ARB_OWNED;
          grant_start = 1'b1;
        end else if (pick_found) begin
          grant_d     = NUM_WARPS'(1) << pick_winner;
          sel_d       = pick_winner;
          state_d     = ARB_OWNED;
          grant_start = 1'b1;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      sel_q         <= '0;
      rr_ptr_q      <= '0;
      pend_q        <= '0;
`ifdef WARP_ARB_TIMEOUT_EN
      hold_q        <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      sel_q         <= sel_d;
      rr_ptr_q      <= rr_ptr_d;
      pend_q        <= pend_d;
`ifdef WARP_ARB_TIMEOUT_EN
      hold_q        <= hold_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign warp_select = sel_q;

endmodule
